dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder: target side of the CPU load/store port. Accepts one
//  request at a time over a valid/ready handshake, applies a fixed access
//  latency, returns a single-cycle response pulse, and commits stores with
//  byte-lane merge. It replaces the zero-latency data memory for the
//  multi-cycle and stall-capable CPU variants.
// PARAMETERS
//  ADDR_W   12  word-index bits; capacity = 2**ADDR_W 32-bit words (16 KiB)
//  LATENCY  2   cycles from request accept to resp_valid; legal range 1..15
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept (high only in IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_sign    in   1   loads: 1 = sign-extend, 0 = zero-extend
//  req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_pc      in   32  PC of issuing instruction, used only for the store log
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  load result, extended; 0 for stores and errors
//  resp_err    out  1   misaligned, out-of-range or illegal size; valid with resp_valid
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//   every memory word cleared to 0. Reset mid-access aborts it; no write, no resp.
//  FSM: IDLE -> BUSY on accept (req_valid & req_ready); latch all req_* fields,
//   cnt <= LATENCY-1. If LATENCY==1, IDLE -> RESP directly.
//   BUSY: cnt decrements each cycle; at cnt==0 go RESP next cycle.
//   RESP: resp_valid=1 for exactly one cycle, then IDLE. Total: resp_valid
//   asserts LATENCY cycles after the accept edge. No response backpressure.
//  req_ready is 0 in BUSY/RESP; inputs are ignored there (requests held by initiator).
//  Next accept is earliest the cycle after RESP (one bubble; no back-to-back).
//  Error checks on latched request: size==11; half with addr[0]!=0; word with
//   addr[1:0]!=0; addr[31:2] >= 2**ADDR_W. Error: resp_err=1, resp_rdata=0, no write.
//  Word index = addr[ADDR_W+1:2]; byte lane = addr[1:0]; half lane = addr[1].
//  Load: extract lane (little-endian, byte 0 = bits [7:0]), extend per req_sign.
//  Store: read-modify-write merge of lane(s) into word; memory updated on the
//   RESP cycle edge. A load in the next transaction sees the new value.
//  Store log (simulation only), on commit:
//   $display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word).
//  Stores of an unchanged value still write and log.
// STRUCTURE
//  dm_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_BAD codes; state enum
//   {ST_IDLE, ST_BUSY, ST_RESP}; LATENCY width constant (4 bits).
//  Sub-module dm_lane_unit (combinational): inputs old word, addr[1:0], size,
//   sign, wdata -> merged store word, extended load data, misalign flag.
//  Top holds FSM, latency counter, request latches, memory array, log.
// TESTING
//  1 Reset then sw 0x12345678 @0x0, lw @0x0 -> resp_valid exactly 2 cycles after
//    each accept, rdata=0x12345678, err=0; log "@<pc>: *00000000 <= 12345678".
//  2 sb 0x80 @0x7, then lb @0x7 -> 0xFFFFFF80; lbu @0x7 -> 0x00000080;
//    lw @0x4 -> 0x80000000.
//  3 sh 0xBEEF @0x2 over word 0x11223344 @0x0 -> word 0xBEEF3344; lh @0x2 ->
//    0xFFFFBEEF; lhu -> 0x0000BEEF.
//  4 lw @0x2, sh @0x1, size=11, lw @0x4000 (ADDR_W=12) -> each: err=1, rdata=0,
//    memory unchanged, no log line.
//  5 req_valid held high continuously -> req_ready low during BUSY/RESP, accepts
//    spaced LATENCY+1 cycles apart; repeat with LATENCY=1 -> spacing 2.
//  6 Accept sw, assert reset next cycle -> no resp_valid, no log, lw @ same addr
//    after reset returns 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the width of the latency counter.
package dm_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dm_state_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane steering for one 32-bit memory word: merges store data into the
// addressed lane(s) and extracts/extends load data, flagging misalignment.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    merged_o   = old_word_i;
    load_o     = '0;
    misalign_o = 1'b0;
    byte_sel   = old_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel   = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    case (size_i)
      SIZE_BYTE: begin
        merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        load_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        misalign_o = addr_lo_i[0];
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
        load_o = {{16{sign_i & half_sel[15]}}, half_sel};
      end
      SIZE_WORD: begin
        misalign_o = |addr_lo_i;
        merged_o   = wdata_i;
        load_o     = old_word_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Target side of the CPU load/store port: one outstanding request, fixed
// access latency, single-cycle response pulse, byte-lane merged stores.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  dm_state_t        state_q;
  logic [LAT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic             sign_q;
  logic [31:0]      wdata_q;
  logic [31:0]      pc_q;
  logic [31:0]      mem_q [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [31:0]       merged_d;
  logic [31:0]       load_data;
  logic              misalign;
  logic              out_of_range;
  logic              err;
  logic              commit;

  assign idx          = addr_q[ADDR_W+1:2];
  assign out_of_range = |addr_q[31:ADDR_W+2];
  assign err          = (size_q == SIZE_BAD) | misalign | out_of_range;
  assign commit       = (state_q == ST_RESP) & we_q & ~err;

  dm_lane_unit u_lane (
    .old_word_i (mem_q[idx]),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .sign_i     (sign_q),
    .wdata_i    (wdata_q),
    .merged_o   (merged_d),
    .load_o     (load_data),
    .misalign_o (misalign)
  );

  // BUSY lasts LATENCY-1 cycles so RESP occupies the LATENCY-th cycle after accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          cnt_q   <= LAT_W'(LATENCY - 1);
          state_q <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
        ST_BUSY: begin
          if (cnt_q <= LAT_W'(1)) state_q <= ST_RESP;
          else                    cnt_q   <= cnt_q - 1'b1;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      sign_q  <= req_sign;
      wdata_q <= req_wdata;
      pc_q    <= req_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[idx] <= merged_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err;
  assign resp_rdata = (resp_valid && !we_q && !err) ? load_data : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && commit)
      $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged_d);
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed and randomized checks of dm_responder against a byte-addressed
// memory model; a second instance with LATENCY=1 covers the short-latency path.
module tb_dm_responder;

  localparam int ADDR_W = 12;
  localparam int LAT    = 2;
  localparam int NBYTES = 4 * (2 ** ADDR_W);

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, r1_valid;
  logic        req_ready, r1_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid, r1_resp_valid;
  logic [31:0] resp_rdata, r1_resp_rdata;
  logic        resp_err, r1_resp_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb [NBYTES];

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign),
    .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign),
    .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(r1_resp_valid),
    .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
  endtask

  // Reference: byte-addressed memory, loads assembled arithmetically.
  task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sign, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata);
    int     nb;
    longint v;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    err   = (nb == 0) || ((addr % nb) != 0) || (longint'(addr) >= NBYTES);
    rdata = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mb[addr + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v + (longint'(mb[addr + i]) << (8 * i));
        if (sign && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (longint'(1) << (8 * nb));
        rdata = 32'(v);
      end
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic sign, input logic [31:0] wdata, input string tag);
    logic        err_e;
    logic [31:0] rd_e;
    int          n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_sign  = sign;
    req_wdata = wdata;
    req_pc    = $urandom;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(we, addr, size, sign, wdata, err_e, rd_e);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
      if (resp_valid) break;
    end
    chk({tag, ".latency"}, 32'(n), 32'(LAT));
    chk({tag, ".rdata"}, resp_rdata, rd_e);
    chk({tag, ".err"}, 32'(resp_err), 32'(err_e));
  endtask

  initial begin
    int acc0 [$];
    int acc1 [$];
    logic [31:0] a;
    logic [1:0]  s;

    reset = 1'b1; req_valid = 1'b0; r1_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_size = 2'b10; req_sign = 1'b0; req_wdata = '0; req_pc = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset.ready", 32'(req_ready), 32'd1);
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.rdata", resp_rdata, 32'd0);
    chk("reset.err", 32'(resp_err), 32'd0);

    xact(1'b1, 32'h0, 2'b10, 1'b0, 32'h12345678, "sw0");
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, "lw0");

    xact(1'b1, 32'h7, 2'b00, 1'b0, 32'h00000080, "sb7");
    xact(1'b0, 32'h7, 2'b00, 1'b1, 32'h0, "lb7");
    xact(1'b0, 32'h7, 2'b00, 1'b0, 32'h0, "lbu7");
    xact(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, "lw4");

    xact(1'b1, 32'h0, 2'b10, 1'b0, 32'h11223344, "sw0b");
    xact(1'b1, 32'h2, 2'b01, 1'b0, 32'h0000BEEF, "sh2");
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, "lw0merged");
    xact(1'b0, 32'h2, 2'b01, 1'b1, 32'h0, "lh2");
    xact(1'b0, 32'h2, 2'b01, 1'b0, 32'h0, "lhu2");

    xact(1'b0, 32'h2, 2'b10, 1'b0, 32'h0, "lw_mis");
    xact(1'b1, 32'h1, 2'b01, 1'b0, 32'h0000AAAA, "sh_mis");
    xact(1'b1, 32'h4, 2'b11, 1'b0, 32'h55555555, "sz_bad");
    xact(1'b0, 32'h4000, 2'b10, 1'b0, 32'h0, "lw_oor");
    xact(1'b1, 32'h4000, 2'b10, 1'b0, 32'hCAFEF00D, "sw_oor");
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, "lw0_after_err");
    xact(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, "lw4_after_err");

    for (int k = 0; k < 40; k++) begin
      s = 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << s) - 32'd1);
      if ($urandom_range(0, 9) == 0) a = a | 32'h4000;
      if ($urandom_range(0, 15) == 0) s = 2'b11;
      xact(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom, "rand");
    end

    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_sign = 1'b0;
    req_valid = 1'b1; r1_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready) acc0.push_back(c);
      if (r1_ready) acc1.push_back(c);
    end
    req_valid = 1'b0; r1_valid = 1'b0;
    chk("held.count_l2", 32'(acc0.size() >= 5), 32'd1);
    chk("held.count_l1", 32'(acc1.size() >= 8), 32'd1);
    for (int i = 1; i < acc0.size(); i++) chk("held.spacing_l2", 32'(acc0[i] - acc0[i-1]), 32'(LAT + 1));
    for (int i = 1; i < acc1.size(); i++) chk("held.spacing_l1", 32'(acc1[i] - acc1[i-1]), 32'd2);
    repeat (5) @(negedge clk);

    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b10;
    req_wdata = 32'hDEADBEEF;
    chk("abort.ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort.no_resp0", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort.no_resp1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("abort.no_resp2", 32'(resp_valid), 32'd0);
    model_clear();
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "lw_after_abort");
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, "lw0_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
